// File: rtl/pilha_retorno.sv
// Return-address stack (LIFO) fed by the control unit's push/pop strobes.
// Optional macro PILHA_CIRCULAR_EN: a push while full overwrites the oldest entry.
module pilha_retorno #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              limpa_erro,
  output logic [DATA_W-1:0] topo,
  output logic [PTR_W:0]    ocupacao,
  output logic              vazia,
  output logic              cheia,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp, sp_next, sp_top, wr_addr;
  logic [PTR_W:0]    cnt, cnt_next;
  logic              empty, full, wr_en, ovf_set, udf_set;

  assign sp_top   = sp - PTR_W'(1);
  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);

  // Top is combinational so the PC can capture it on the same edge as the pop.
  assign topo     = empty ? '0 : mem[sp_top];
  assign ocupacao = cnt;
  assign vazia    = empty;
  assign cheia    = full;

  always_comb begin
    sp_next  = sp;
    cnt_next = cnt;
    wr_en    = 1'b0;
    wr_addr  = sp;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en    = 1'b1;
          sp_next  = sp + PTR_W'(1);
          cnt_next = cnt + (PTR_W+1)'(1);
        end else begin
          ovf_set = 1'b1;
`ifdef PILHA_CIRCULAR_EN
          wr_en   = 1'b1;
          sp_next = sp + PTR_W'(1);
`else
          wr_en   = 1'b0;
`endif
        end
      end
      2'b01: begin
        if (!empty) begin
          sp_next  = sp_top;
          cnt_next = cnt - (PTR_W+1)'(1);
        end else begin
          udf_set = 1'b1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        if (!empty) begin
          wr_addr = sp_top;
        end else begin
          // Simultaneous push/pop on an empty stack behaves as a plain push into slot 0.
          wr_addr  = '0;
          sp_next  = PTR_W'(1);
          cnt_next = (PTR_W+1)'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pc_in;
  end

  // Error flags: a new event on the same edge as limpa_erro keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      cnt       <= cnt_next;
      overflow  <= ovf_set | (overflow & ~limpa_erro);
      underflow <= udf_set | (underflow & ~limpa_erro);
    end
  end

endmodule
